cmd_frame_decoder: RTL and testbench

CMD_FRAME_DECODER -- requirements
Module: cmd_frame_decoder

---
 rtl/cmd_frame_decoder.sv | 154 +++++++++++++++
 tb/tb_cmd_frame_decoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_decoder.sv
// Decodes 6-byte UART command frames (HEAD1 HEAD2 ADDR DATA_H DATA_L CHK) into
// single-cycle register writes, with checksum and inter-byte timeout checking.
module cmd_frame_decoder #(
  parameter logic [7:0]  HEAD1          = 8'h55,
  parameter logic [7:0]  HEAD2          = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  Rx_Byte,
  input  logic        Rx_Done,
  output logic        m_wr,
  output logic [7:0]  m_addr,
  output logic [15:0] m_wrdata,
  output logic        Frame_Err,
  output logic        Busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_H2   = 3'd1,
    S_ADDR = 3'd2,
    S_DH   = 3'd3,
    S_DL   = 3'd4,
    S_CHK  = 3'd5
  } state_t;

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  state_t      state_s;
  logic [19:0] tmo_cnt_r;
  logic [7:0]  addr_r;
  logic [7:0]  data_h_r;
  logic [7:0]  data_l_r;
  logic        m_wr_r;
  logic [7:0]  m_addr_r;
  logic [15:0] m_wrdata_r;
  logic        frame_err_r;
  logic        busy_r;
  logic        timeout_s;
  logic        chk_ok_s;
  logic        wr_s;
  logic        err_s;

  // Carries are discarded: the 8-bit result is the frame checksum.
  function automatic logic [7:0] frame_checksum(input logic [7:0] a,
                                                input logic [7:0] b,
                                                input logic [7:0] c);
    return a + b + c;
  endfunction

  assign m_wr      = m_wr_r;
  assign m_addr    = m_addr_r;
  assign m_wrdata  = m_wrdata_r;
  assign Frame_Err = frame_err_r;
  assign Busy      = busy_r;

  // Next-state decode; a byte arriving on the expiry cycle beats the timeout.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    chk_ok_s  = (Rx_Byte == frame_checksum(addr_r, data_h_r, data_l_r));
    wr_s      = 1'b0;
    err_s     = 1'b0;
    if (Rx_Done) begin
      case (state_r)
        S_IDLE: begin
          if (Rx_Byte == HEAD1) begin
            state_s = S_H2;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_H2: begin
          if (Rx_Byte == HEAD2) begin
            state_s = S_ADDR;
          end else if (Rx_Byte == HEAD1) begin
            state_s = S_H2;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_ADDR:  state_s = S_DH;
        S_DH:    state_s = S_DL;
        S_DL:    state_s = S_CHK;
        S_CHK: begin
          state_s = S_IDLE;
          wr_s    = chk_ok_s;
          err_s   = ~chk_ok_s;
        end
        default: state_s = S_IDLE;
      endcase
    end else if ((state_r != S_IDLE) && (tmo_cnt_r == TMO_LAST)) begin
      timeout_s = 1'b1;
      err_s     = 1'b1;
      state_s   = S_IDLE;
    end else begin
      state_s = state_r;
    end
  end

  // State register and inter-byte gap counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r   <= S_IDLE;
      tmo_cnt_r <= 20'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == S_IDLE) || Rx_Done) begin
        tmo_cnt_r <= 20'd0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + 20'd1;
      end
    end
  end

  // Payload holding registers; header values are plain payload here.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_r   <= 8'd0;
      data_h_r <= 8'd0;
      data_l_r <= 8'd0;
    end else if (Rx_Done) begin
      case (state_r)
        S_ADDR:  addr_r   <= Rx_Byte;
        S_DH:    data_h_r <= Rx_Byte;
        S_DL:    data_l_r <= Rx_Byte;
        default: begin
        end
      endcase
    end
  end

  // Registered outputs; address and data only move on an accepted frame.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_wr_r      <= 1'b0;
      m_addr_r    <= 8'd0;
      m_wrdata_r  <= 16'd0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      m_wr_r      <= wr_s;
      frame_err_r <= err_s;
      busy_r      <= (state_s != S_IDLE);
      if (wr_s) begin
        m_addr_r   <= addr_r;
        m_wrdata_r <= {data_h_r, data_l_r};
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Bench for cmd_frame_decoder: directed vector table, hand-built timeout and
// reset sequences, and randomized frames checked against a byte-buffer model.
module tb_cmd_frame_decoder;

  localparam logic [7:0] H1  = 8'h55;
  localparam logic [7:0] H2  = 8'hA5;
  localparam int         TMO = 100;

  logic        Clk;
  logic        Rst_n;
  logic [7:0]  Rx_Byte;
  logic        Rx_Done;
  logic        m_wr;
  logic [7:0]  m_addr;
  logic [15:0] m_wrdata;
  logic        Frame_Err;
  logic        Busy;

  int checks;
  int failures;

  cmd_frame_decoder #(.HEAD1(H1), .HEAD2(H2), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rx_Byte(Rx_Byte), .Rx_Done(Rx_Done),
    .m_wr(m_wr), .m_addr(m_addr), .m_wrdata(m_wrdata),
    .Frame_Err(Frame_Err), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: bytes of the frame collected so far and silent cycles since the last byte.
  logic [7:0]  frame_q[$];
  int          gap;
  logic        exp_wr;
  logic        exp_err;
  logic        exp_busy;
  logic [7:0]  exp_addr;
  logic [15:0] exp_data;

  typedef struct {
    logic [7:0]  b;
    logic        wr;
    logic        err;
    logic        busy;
    logic [7:0]  addr;
    logic [15:0] data;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    gap      = 0;
    exp_wr   = 1'b0;
    exp_err  = 1'b0;
    exp_busy = 1'b0;
    exp_addr = 8'h00;
    exp_data = 16'h0000;
  endtask

  task automatic model_step(input logic rxd, input logic [7:0] b);
    int sum;
    exp_wr  = 1'b0;
    exp_err = 1'b0;
    if (rxd) begin
      gap = 0;
      if (frame_q.size() == 0) begin
        if (b == H1) frame_q.push_back(b);
      end else if (frame_q.size() == 1) begin
        if (b == H2) frame_q.push_back(b);
        else if (b != H1) frame_q.delete();
      end else if (frame_q.size() < 5) begin
        frame_q.push_back(b);
      end else begin
        sum = (int'(frame_q[2]) + int'(frame_q[3]) + int'(frame_q[4])) % 256;
        if (sum == int'(b)) begin
          exp_wr   = 1'b1;
          exp_addr = frame_q[2];
          exp_data = {frame_q[3], frame_q[4]};
        end else begin
          exp_err = 1'b1;
        end
        frame_q.delete();
      end
    end else if (frame_q.size() != 0) begin
      gap++;
      if (gap == TMO) begin
        exp_err = 1'b1;
        frame_q.delete();
        gap = 0;
      end
    end
    exp_busy = (frame_q.size() != 0);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".m_wr"},      32'(m_wr),      32'(exp_wr));
    check({tag, ".Frame_Err"}, 32'(Frame_Err), 32'(exp_err));
    check({tag, ".Busy"},      32'(Busy),      32'(exp_busy));
    check({tag, ".m_addr"},    32'(m_addr),    32'(exp_addr));
    check({tag, ".m_wrdata"},  32'(m_wrdata),  32'(exp_data));
  endtask

  task automatic drive_cycle(input logic rxd, input logic [7:0] b, input string tag);
    Rx_Done = rxd;
    Rx_Byte = b;
    @(posedge Clk);
    #1;
    Rx_Done = 1'b0;
    model_step(rxd, b);
    compare_all(tag);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'($urandom), tag);
  endtask

  task automatic send_bytes(input logic [7:0] bs[$], input string tag);
    foreach (bs[i]) drive_cycle(1'b1, bs[i], tag);
  endtask

  task automatic apply_reset();
    Rx_Done = 1'b0;
    Rst_n   = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    @(posedge Clk);
    #1;
    compare_all("reset_hold");
    Rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [7:0] b, input logic wr, input logic err,
                              input logic busy, input logic [7:0] addr, input logic [15:0] data);
    vec_t v;
    v.b = b; v.wr = wr; v.err = err; v.busy = busy; v.addr = addr; v.data = data;
    return v;
  endfunction

  initial begin
    logic [7:0] fr[$];
    logic [7:0] a, dh, dl, chk;
    int         kind, len, g;

    checks   = 0;
    failures = 0;
    Rst_n    = 1'b0;
    Rx_Done  = 1'b0;
    Rx_Byte  = 8'h00;
    model_reset();
    @(posedge Clk);
    #1;
    apply_reset();

    // Back-to-back directed frames: good, bad checksum, H2 resync, header bytes as payload, abort in H2.
    vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000));
    vecs.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000));
    vecs.push_back(mk(8'h07, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000));
    vecs.push_back(mk(8'h83, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000));
    vecs.push_back(mk(8'h8A, 1'b1, 1'b0, 1'b0, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h06, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h01, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h0C, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h01, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0083));
    vecs.push_back(mk(8'h0D, 1'b1, 1'b0, 1'b0, 8'h0C, 16'h0001));
    vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b1, 8'h0C, 16'h0001));
    vecs.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b1, 8'h0C, 16'h0001));
    vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b1, 8'h0C, 16'h0001));
    vecs.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b1, 8'h0C, 16'h0001));
    vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b1, 8'h0C, 16'h0001));
    vecs.push_back(mk(8'h4F, 1'b1, 1'b0, 1'b0, 8'h55, 16'hA555));
    vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 16'hA555));
    vecs.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b1, 8'h55, 16'hA555));
    vecs.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b1, 8'h55, 16'hA555));
    vecs.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b1, 8'h55, 16'hA555));
    vecs.push_back(mk(8'h03, 1'b0, 1'b0, 1'b1, 8'h55, 16'hA555));
    vecs.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0, 8'hFF, 16'hFF03));
    vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b1, 8'hFF, 16'hFF03));
    vecs.push_back(mk(8'h12, 1'b0, 1'b0, 1'b0, 8'hFF, 16'hFF03));
    vecs.push_back(mk(8'h33, 1'b0, 1'b0, 1'b0, 8'hFF, 16'hFF03));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(1'b1, vecs[i].b, "vec_model");
      check("vec.m_wr",      32'(m_wr),      32'(vecs[i].wr));
      check("vec.Frame_Err", 32'(Frame_Err), 32'(vecs[i].err));
      check("vec.Busy",      32'(Busy),      32'(vecs[i].busy));
      check("vec.m_addr",    32'(m_addr),    32'(vecs[i].addr));
      check("vec.m_wrdata",  32'(m_wrdata),  32'(vecs[i].data));
    end
    drive_cycle(1'b0, 8'h00, "vec_tail");
    check("vec_tail.m_wr", 32'(m_wr), 32'd0);

    // Timeout: 99 silent cycles keep the frame, the 100th expires it.
    send_bytes('{8'h55, 8'hA5, 8'h08}, "tmo_hdr");
    idle_cycles(TMO - 1, "tmo_wait");
    check("tmo_pre.Busy",      32'(Busy),      32'd1);
    check("tmo_pre.Frame_Err", 32'(Frame_Err), 32'd0);
    drive_cycle(1'b0, 8'h00, "tmo_edge");
    check("tmo.Frame_Err", 32'(Frame_Err), 32'd1);
    check("tmo.Busy",      32'(Busy),      32'd0);
    drive_cycle(1'b0, 8'h00, "tmo_after");
    check("tmo_after.Frame_Err", 32'(Frame_Err), 32'd0);
    send_bytes('{8'h55, 8'hA5, 8'h21, 8'h43, 8'h65, 8'hC9}, "tmo_next");
    check("tmo_next.m_wr",     32'(m_wr),     32'd1);
    check("tmo_next.m_addr",   32'(m_addr),   32'h21);
    check("tmo_next.m_wrdata", 32'(m_wrdata), 32'h4365);

    // Each byte arrives on the last cycle before expiry: no timeout.
    drive_cycle(1'b1, 8'h55, "near");
    idle_cycles(TMO - 1, "near");
    drive_cycle(1'b1, 8'hA5, "near");
    foreach (fr[i]) fr.delete(i);
    fr = '{8'h08, 8'h00, 8'h08, 8'h10};
    foreach (fr[i]) begin
      idle_cycles(TMO - 1, "near");
      drive_cycle(1'b1, fr[i], "near");
      if (i < 3) check("near.Frame_Err", 32'(Frame_Err), 32'd0);
    end
    check("near.m_wr",     32'(m_wr),     32'd1);
    check("near.m_addr",   32'(m_addr),   32'h08);
    check("near.m_wrdata", 32'(m_wrdata), 32'h0008);

    // Reset mid-frame discards it; a following lone byte writes nothing.
    send_bytes('{8'h55, 8'hA5, 8'h09}, "rst_frame");
    apply_reset();
    check("rst.m_addr",   32'(m_addr),   32'h00);
    check("rst.m_wrdata", 32'(m_wrdata), 32'h0000);
    drive_cycle(1'b1, 8'h12, "rst_after");
    check("rst_after.m_wr", 32'(m_wr), 32'd0);
    check("rst_after.Busy", 32'(Busy), 32'd0);
    idle_cycles(3, "rst_idle");

    // Randomized frames: good, corrupted, junk-prefixed and truncated, with mixed gaps.
    for (int f = 0; f < 250; f++) begin
      kind = $urandom_range(0, 9);
      a  = 8'($urandom);
      dh = 8'($urandom);
      dl = 8'($urandom);
      chk = a + dh + dl;
      if (kind == 0) chk = chk ^ 8'($urandom_range(1, 255));
      fr.delete();
      if (kind == 1) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) fr.push_back(($urandom_range(0, 2) == 0) ? H1 : 8'($urandom));
      end
      fr.push_back(H1);
      fr.push_back(H2);
      fr.push_back(a);
      fr.push_back(dh);
      fr.push_back(dl);
      fr.push_back(chk);
      if (kind == 2) begin
        len = $urandom_range(1, 5);
        while (fr.size() > len) void'(fr.pop_back());
      end
      foreach (fr[i]) begin
        g = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 3, TMO + 3) : $urandom_range(0, 3);
        idle_cycles(g, "rand");
        drive_cycle(1'b1, fr[i], "rand");
      end
      if (kind == 2) idle_cycles(TMO + 1, "rand_trunc");
      if ($urandom_range(0, 49) == 0) begin
        apply_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
